// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD command feeder.
// Optional build macro: LCD_FEEDER_CMD_CHECK_EN (see lcd_cmd_feeder).
package lcd_pkg;

    localparam logic [3:0]  CMD_LOAD           = 4'd0;
    localparam int unsigned IMG_PIXELS_DEFAULT = 108;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StStream,
        StGap
    } state_e;

    // Codes 8-15 fall outside the controller's command set.
    function automatic logic is_illegal(input logic [3:0] code);
        return code[3];
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small circular FIFO for 4-bit host command codes; Depth must be a power of 2.
module lcd_cmd_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [3:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [3:0] head_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [3:0]    mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Queues host commands and feeds them to an LCD controller, streaming an image on LOAD.
// Define LCD_FEEDER_CMD_CHECK_EN to drop codes 8-15 and flag them on err_illegal.
module lcd_cmd_feeder
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned IMG_PIXELS = IMG_PIXELS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_push,
    output logic       host_full,
    output logic [6:0] img_addr,
    output logic       img_rd,
    input  logic [7:0] img_data,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    output logic       idle,
    output logic       err_overflow,
    output logic       err_illegal
);

    localparam logic [6:0] LAST_PIX = 7'(IMG_PIXELS - 1);

    state_e     state_q, state_d;
    logic [3:0] cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       img_rd_q, img_rd_d;
    logic [6:0] img_addr_q, img_addr_d;
    logic [6:0] pix_q, pix_d;
    logic [6:0] pix_nxt;
    logic       load_q, load_d;
    logic       err_ovf_q, err_ovf_d;
`ifdef LCD_FEEDER_CMD_CHECK_EN
    logic       err_ill_q, err_ill_d;
`endif

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [3:0] fifo_head;

    lcd_cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (host_push),
        .data_i  (host_cmd),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign pix_nxt = pix_q + 7'd1;

    always_comb begin
        state_d     = state_q;
        cmd_d       = 4'd0;
        cmd_valid_d = 1'b0;
        img_rd_d    = 1'b0;
        img_addr_d  = 7'd0;
        pix_d       = pix_q;
        load_d      = load_q;
        fifo_pop    = 1'b0;
        err_ovf_d   = err_ovf_q | (host_push & fifo_full);
`ifdef LCD_FEEDER_CMD_CHECK_EN
        err_ill_d   = err_ill_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Outputs are registered, so the ISSUE cycle is set up on entry.
                if (!fifo_empty && !busy) begin
                    fifo_pop = 1'b1;
                    state_d  = StIssue;
                    load_d   = (fifo_head == CMD_LOAD);
`ifdef LCD_FEEDER_CMD_CHECK_EN
                    if (is_illegal(fifo_head)) begin
                        err_ill_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = fifo_head;
                    end
`else
                    cmd_valid_d = 1'b1;
                    cmd_d       = fifo_head;
`endif
                    if (fifo_head == CMD_LOAD) begin
                        img_rd_d   = 1'b1;
                        img_addr_d = 7'd0;
                    end
                end
            end
            StIssue: begin
                if (load_q) begin
                    state_d    = StStream;
                    pix_d      = 7'd0;
                    img_rd_d   = (LAST_PIX != 7'd0);
                    img_addr_d = 7'd1;
                end else begin
                    state_d = StGap;
                end
            end
            StStream: begin
                if (pix_q == LAST_PIX) begin
                    state_d = StGap;
                end else begin
                    pix_d = pix_nxt;
                    // Fetch one pixel ahead of the one being streamed.
                    if (pix_nxt < LAST_PIX) begin
                        img_rd_d   = 1'b1;
                        img_addr_d = pix_nxt + 7'd1;
                    end
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cmd_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            img_rd_q    <= 1'b0;
            img_addr_q  <= 7'd0;
            pix_q       <= 7'd0;
            load_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            img_rd_q    <= img_rd_d;
            img_addr_q  <= img_addr_d;
            pix_q       <= pix_d;
            load_q      <= load_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

`ifdef LCD_FEEDER_CMD_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_ill_q <= 1'b0;
        end else begin
            err_ill_q <= err_ill_d;
        end
    end
    assign err_illegal = err_ill_q;
`else
    assign err_illegal = 1'b0;
`endif

    assign cmd          = cmd_q;
    assign cmd_valid    = cmd_valid_q;
    assign img_rd       = img_rd_q;
    assign img_addr     = img_addr_q;
    assign err_overflow = err_ovf_q;
    assign host_full    = fifo_full;
    assign idle         = (state_q == StIdle) && fifo_empty;
    assign datain       = (state_q == StStream) ? img_data : 8'd0;

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Directed self-checking bench for lcd_cmd_feeder with a ROM model holding ROM[k]=k+1.
module tb_lcd_cmd_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] host_cmd = 4'd0;
    logic       host_push = 1'b0;
    logic       host_full;
    logic [6:0] img_addr;
    logic       img_rd;
    logic [7:0] img_data = 8'd0;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy = 1'b0;
    logic       idle;
    logic       err_overflow;
    logic       err_illegal;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    lcd_cmd_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_push    (host_push),
        .host_full    (host_full),
        .img_addr     (img_addr),
        .img_rd       (img_rd),
        .img_data     (img_data),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .busy         (busy),
        .idle         (idle),
        .err_overflow (err_overflow),
        .err_illegal  (err_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (img_rd) img_data <= {1'b0, img_addr} + 8'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at 2ms, required finished");
        $fatal(1, "timeout");
    end

    // All tasks start and end just after a falling edge.
    task automatic push_cmd(input logic [3:0] c);
        host_cmd  = c;
        host_push = 1'b1;
        @(negedge clk);
        host_push = 1'b0;
    endtask

    task automatic wait_cmd_valid(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (cmd_valid) begin
                found = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (cmd_valid !== 1'b0) begin $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); miscompares++; end
        vectors++; if (cmd !== 4'd0) begin $display("FAIL rst_cmd: got %0d want 0", cmd); miscompares++; end
        vectors++; if (img_rd !== 1'b0) begin $display("FAIL rst_img_rd: got %b want 0", img_rd); miscompares++; end
        vectors++; if (img_addr !== 7'd0) begin $display("FAIL rst_img_addr: got %0d want 0", img_addr); miscompares++; end
        vectors++; if (datain !== 8'd0) begin $display("FAIL rst_datain: got %0d want 0", datain); miscompares++; end
        vectors++; if (host_full !== 1'b0) begin $display("FAIL rst_host_full: got %b want 0", host_full); miscompares++; end
        vectors++; if (idle !== 1'b1) begin $display("FAIL rst_idle: got %b want 1", idle); miscompares++; end
        vectors++; if (err_overflow !== 1'b0) begin $display("FAIL rst_err_overflow: got %b want 0", err_overflow); miscompares++; end
        vectors++; if (err_illegal !== 1'b0) begin $display("FAIL rst_err_illegal: got %b want 0", err_illegal); miscompares++; end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        bit found;
        busy = 1'b0;
        push_cmd(4'd0);
        wait_cmd_valid(10, found);
        vectors++;
        if (!found) begin
            $display("FAIL load_issue: cmd_valid got 0 for 10 cycles, want 1");
            miscompares++;
            return;
        end
        vectors++; if (cmd !== 4'd0) begin $display("FAIL load_cmd: got %0d want 0", cmd); miscompares++; end
        vectors++; if (img_rd !== 1'b1 || img_addr !== 7'd0) begin
            $display("FAIL load_first_rd: got rd=%b addr=%0d want rd=1 addr=0", img_rd, img_addr); miscompares++; end
        for (int k = 0; k < 108; k++) begin
            @(negedge clk);
            vectors++;
            if (datain !== 8'(k + 1)) begin
                $display("FAIL load_pixel_%0d: datain got %0d want %0d", k, datain, k + 1); miscompares++; end
            vectors++;
            if (k < 107) begin
                if (img_rd !== 1'b1 || img_addr !== 7'(k + 1)) begin
                    $display("FAIL load_rd_%0d: got rd=%b addr=%0d want rd=1 addr=%0d", k, img_rd, img_addr, k + 1);
                    miscompares++;
                end
            end else if (img_rd !== 1'b0) begin
                $display("FAIL load_rd_last: img_rd got %b want 0", img_rd); miscompares++;
            end
            vectors++;
            if (cmd_valid !== 1'b0) begin
                $display("FAIL load_no_valid_%0d: cmd_valid got %b want 0", k, cmd_valid); miscompares++; end
        end
        @(negedge clk);
        vectors++; if (datain !== 8'd0) begin $display("FAIL load_datain_after: got %0d want 0", datain); miscompares++; end
        @(negedge clk);
        vectors++; if (idle !== 1'b1) begin $display("FAIL load_idle_after: got %b want 1", idle); miscompares++; end
    endtask

    task automatic test_busy_wait();
        int early = 0;
        busy = 1'b1;
        push_cmd(4'd3);
        for (int i = 0; i < 19; i++) begin
            if (cmd_valid) early++;
            @(negedge clk);
        end
        if (cmd_valid) early++;
        vectors++; if (early != 0) begin $display("FAIL busy_hold: cmd_valid pulses got %0d want 0", early); miscompares++; end
        busy = 1'b0;
        @(negedge clk);
        vectors++; if (cmd_valid !== 1'b1 || cmd !== 4'd3) begin
            $display("FAIL busy_release: got valid=%b cmd=%0d want valid=1 cmd=3", cmd_valid, cmd); miscompares++; end
        @(negedge clk);
        @(negedge clk);
        vectors++; if (idle !== 1'b1) begin $display("FAIL busy_idle_after: got %b want 1", idle); miscompares++; end
    endtask

    task automatic test_overflow();
        logic [3:0] got[$];
        int         t[$];
        busy = 1'b1;
        push_cmd(4'd1);
        push_cmd(4'd2);
        push_cmd(4'd3);
        vectors++; if (host_full !== 1'b0) begin $display("FAIL ovf_not_full_3: got %b want 0", host_full); miscompares++; end
        push_cmd(4'd4);
        vectors++; if (host_full !== 1'b1) begin $display("FAIL ovf_full_4: got %b want 1", host_full); miscompares++; end
        vectors++; if (err_overflow !== 1'b0) begin $display("FAIL ovf_flag_early: got %b want 0", err_overflow); miscompares++; end
        push_cmd(4'd5);
        vectors++; if (err_overflow !== 1'b1) begin $display("FAIL ovf_flag: got %b want 1", err_overflow); miscompares++; end
        busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                got.push_back(cmd);
                t.push_back(cyc);
            end
        end
        vectors++;
        if (got.size() != 4) begin
            $display("FAIL ovf_issue_count: got %0d want 4", got.size()); miscompares++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[i] !== 4'(i + 1)) begin
                    $display("FAIL ovf_order_%0d: cmd got %0d want %0d", i, got[i], i + 1); miscompares++; end
            end
            vectors++;
            if (t[1] - t[0] != 3 || t[3] - t[2] != 3) begin
                $display("FAIL ovf_spacing: gaps got %0d,%0d want 3,3", t[1] - t[0], t[3] - t[2]); miscompares++; end
        end
        vectors++; if (err_overflow !== 1'b1) begin $display("FAIL ovf_sticky: got %b want 1", err_overflow); miscompares++; end
        vectors++; if (idle !== 1'b1) begin $display("FAIL ovf_idle_after: got %b want 1", idle); miscompares++; end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got[$];
        int         t[$];
        int         dirty = 0;
        busy = 1'b0;
        host_cmd = 4'd2; host_push = 1'b1;
        @(negedge clk);
        host_cmd = 4'd4;
        @(negedge clk);
        host_push = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_valid) begin
                got.push_back(cmd);
                t.push_back(cyc);
            end else if (cmd !== 4'd0) begin
                dirty++;
            end
            @(negedge clk);
        end
        vectors++;
        if (got.size() != 2) begin
            $display("FAIL b2b_count: got %0d want 2", got.size()); miscompares++;
        end else begin
            vectors++; if (got[0] !== 4'd2 || got[1] !== 4'd4) begin
                $display("FAIL b2b_order: got %0d,%0d want 2,4", got[0], got[1]); miscompares++; end
            vectors++; if (t[1] - t[0] != 3) begin
                $display("FAIL b2b_spacing: got %0d want 3", t[1] - t[0]); miscompares++; end
        end
        vectors++; if (dirty != 0) begin $display("FAIL b2b_cmd_zero: nonzero cmd cycles got %0d want 0", dirty); miscompares++; end
    endtask

    task automatic test_illegal();
        int n = 0;
        logic [3:0] last = 4'd0;
        busy = 1'b0;
        push_cmd(4'd9);
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid) begin n++; last = cmd; end
            @(negedge clk);
        end
`ifdef LCD_FEEDER_CMD_CHECK_EN
        vectors++; if (n != 0) begin $display("FAIL ill_dropped: pulses got %0d want 0", n); miscompares++; end
        vectors++; if (err_illegal !== 1'b1) begin $display("FAIL ill_flag: got %b want 1", err_illegal); miscompares++; end
`else
        vectors++; if (n != 1 || last !== 4'd9) begin
            $display("FAIL ill_forward: pulses=%0d cmd=%0d want pulses=1 cmd=9", n, last); miscompares++; end
        vectors++; if (err_illegal !== 1'b0) begin $display("FAIL ill_flag: got %b want 0", err_illegal); miscompares++; end
`endif
        vectors++; if (idle !== 1'b1) begin $display("FAIL ill_idle_after: got %b want 1", idle); miscompares++; end
    endtask

    task automatic test_reset_mid_load();
        bit found;
        int n = 0;
        busy = 1'b0;
        push_cmd(4'd0);
        wait_cmd_valid(10, found);
        vectors++;
        if (!found) begin
            $display("FAIL rml_issue: cmd_valid got 0 for 10 cycles, want 1");
            miscompares++;
            return;
        end
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 5) busy = 1'b1;
            if (k == 10) begin host_cmd = 4'd5; host_push = 1'b1; end
            if (k == 11) host_push = 1'b0;
        end
        vectors++; if (datain !== 8'd51) begin $display("FAIL rml_pixel_50: datain got %0d want 51", datain); miscompares++; end
        reset = 1'b0;
        #1;
        vectors++; if (cmd_valid !== 1'b0 || cmd !== 4'd0) begin
            $display("FAIL rml_cmd: got valid=%b cmd=%0d want 0,0", cmd_valid, cmd); miscompares++; end
        vectors++; if (img_rd !== 1'b0 || img_addr !== 7'd0) begin
            $display("FAIL rml_img: got rd=%b addr=%0d want 0,0", img_rd, img_addr); miscompares++; end
        vectors++; if (datain !== 8'd0) begin $display("FAIL rml_datain: got %0d want 0", datain); miscompares++; end
        vectors++; if (idle !== 1'b1 || host_full !== 1'b0) begin
            $display("FAIL rml_idle_full: got idle=%b full=%b want 1,0", idle, host_full); miscompares++; end
        vectors++; if (err_overflow !== 1'b0 || err_illegal !== 1'b0) begin
            $display("FAIL rml_errs: got ovf=%b ill=%b want 0,0", err_overflow, err_illegal); miscompares++; end
        @(negedge clk);
        reset = 1'b1;
        busy  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid) n++;
        end
        vectors++; if (n != 0) begin $display("FAIL rml_no_issue: pulses got %0d want 0", n); miscompares++; end
        vectors++; if (idle !== 1'b1) begin $display("FAIL rml_idle_after: got %b want 1", idle); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_load();
        test_busy_wait();
        test_overflow();
        test_back_to_back();
        test_illegal();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_feeder.md
LCD_CMD_FEEDER -- requirements
Module: lcd_cmd_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued host commands (power of 2, at least 2).
REQ-002 SHALL have parameter IMG_PIXELS, default 108, meaning the pixels streamed per load command (12x9 image).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port host_cmd, input, 4 bits: command code to enqueue.
REQ-006 SHALL have port host_push, input, 1 bit: enqueue host_cmd this cycle.
REQ-007 SHALL have port host_full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-008 SHALL have port img_addr, output, 7 bits: image memory read address.
REQ-009 SHALL have port img_rd, output, 1 bit: image memory read strobe.
REQ-010 SHALL have port img_data, input, 8 bits: read data, valid exactly 1 cycle after img_rd.
REQ-011 SHALL have port cmd, output, 4 bits: command to the LCD controller.
REQ-012 SHALL have port cmd_valid, output, 1 bit: cmd is valid, 1-cycle pulse.
REQ-013 SHALL have port datain, output, 8 bits: pixel stream to the LCD controller.
REQ-014 SHALL have port busy, input, 1 bit: LCD controller cannot accept a command.
REQ-015 SHALL have port idle, output, 1 bit: FSM in IDLE and FIFO empty.
REQ-016 SHALL have port err_overflow, output, 1 bit: sticky flag, push attempted while full.
REQ-017 SHALL have port err_illegal, output, 1 bit: sticky flag, illegal code dropped (see Configuration).

Function
REQ-018 SHALL enqueue on host_push when not full; push while full SHALL be dropped and set err_overflow, even if a pop occurs the same cycle.
REQ-019 SHALL treat code 0 as LOAD; codes 1-7 SHALL be plain commands.
REQ-020 SHALL implement FSM states IDLE, ISSUE, STREAM, GAP.
REQ-021 IDLE SHALL go to ISSUE when FIFO is non-empty and busy==0 is sampled; otherwise it SHALL stay in IDLE.
REQ-022 ISSUE SHALL last 1 cycle with cmd_valid=1 and cmd=FIFO head, and SHALL pop the head.
REQ-023 ISSUE of a LOAD SHALL also assert img_rd with img_addr=0, then go to STREAM; otherwise ISSUE SHALL go to GAP.
REQ-024 STREAM SHALL last exactly IMG_PIXELS cycles, with datain=img_data on stream cycle k (k=0..IMG_PIXELS-1) carrying pixel k.
REQ-025 In STREAM, img_rd SHALL assert with img_addr=k+1 while k+1<IMG_PIXELS; after the last pixel the FSM SHALL go to GAP.
REQ-026 GAP SHALL last 1 cycle, giving the controller time to assert busy, then go to IDLE.
REQ-027 Commands SHALL issue in FIFO order, at most one every 3 cycles.
REQ-028 cmd and cmd_valid SHALL be registered.
REQ-029 datain SHALL be combinational from img_data in STREAM and 0 otherwise.
REQ-030 cmd SHALL be 0 whenever cmd_valid=0.
REQ-031 busy SHALL be ignored outside IDLE.
REQ-032 host_push in the same cycle the FIFO empties SHALL be accepted normally.

Reset
REQ-033 On reset=0, immediately: FSM=IDLE, FIFO empty, cmd=0, cmd_valid=0, img_rd=0, img_addr=0, datain=0, host_full=0, idle=1, both error flags=0.
REQ-034 Reset mid-STREAM SHALL abort the stream; queued commands SHALL be discarded.

Configuration
REQ-035 With LCD_FEEDER_CMD_CHECK_EN defined, codes 8-15 SHALL be popped in ISSUE without asserting cmd_valid and SHALL set err_illegal, then go to GAP.
REQ-036 Without LCD_FEEDER_CMD_CHECK_EN, all codes SHALL be forwarded unchanged and err_illegal SHALL be tied 0.

Structure
REQ-037 Package lcd_pkg SHALL hold the command code constants (CMD_LOAD=0), IMG_PIXELS default, and the FSM state enum.
REQ-038 The FIFO SHALL be a sub-module lcd_cmd_fifo (push/pop/full/empty/head).

Verification
REQ-039 Load: ROM[k]=k+1, busy=0, push 0 -> one cmd_valid with cmd=0, img_addr 0..107, then datain 1..108 on 108 consecutive cycles, then datain=0.
REQ-040 Busy wait: busy=1 for 20 cycles, push 3 -> no cmd_valid while busy=1; cmd_valid with cmd=3 in the cycle after the first busy=0 sample.
REQ-041 Overflow: busy=1, push 1,2,3,4,5 -> host_full after the 4th push, err_overflow=1; after busy drops, 1,2,3,4 issue in order and 5 never issues.
REQ-042 Back-to-back: busy=0, push 2,4 -> cmd_valid pulses exactly 3 cycles apart.
REQ-043 Illegal code: push 9 -> with macro, no cmd_valid and err_illegal=1; without macro, cmd=9 is issued and err_illegal=0.
REQ-044 Reset mid-load: reset=0 at pixel 50 -> all outputs at reset values immediately; after release, idle=1 and no further cmd_valid.
